// File: rtl/axi_spi_regs.sv
// AXI4-Lite register front end for the SPI controller.
// Maps bus accesses onto config levels, reset pulses and FIFO handshakes.
module axi_spi_regs #(
  parameter int ADDR_WIDTH      = 6,
  parameter int REG_WIDTH       = 32,
  parameter int DATA_WIDTH      = 8,
  parameter int SPI_RATIO_GRADE = 2,
  parameter int SR_RX_EMPTY_BIT = 0,
  parameter int SR_TX_FULL_BIT  = 3
) (
  input  logic                       clk_i,
  input  logic                       arst_n_i,
  input  logic [ADDR_WIDTH-1:0]      s_axi_awaddr_i,
  input  logic                       s_axi_awvalid_i,
  output logic                       s_axi_awready_o,
  input  logic [REG_WIDTH-1:0]       s_axi_wdata_i,
  input  logic [REG_WIDTH/8-1:0]     s_axi_wstrb_i,
  input  logic                       s_axi_wvalid_i,
  output logic                       s_axi_wready_o,
  output logic [1:0]                 s_axi_bresp_o,
  output logic                       s_axi_bvalid_o,
  input  logic                       s_axi_bready_i,
  input  logic [ADDR_WIDTH-1:0]      s_axi_araddr_i,
  input  logic                       s_axi_arvalid_i,
  output logic                       s_axi_arready_o,
  output logic [REG_WIDTH-1:0]       s_axi_rdata_o,
  output logic [1:0]                 s_axi_rresp_o,
  output logic                       s_axi_rvalid_o,
  input  logic                       s_axi_rready_i,
  output logic                       soft_rst_o,
  output logic                       slave_select_o,
  output logic                       control_lsb_o,
  output logic                       control_cpha_o,
  output logic                       control_cpol_o,
  output logic                       control_master_o,
  output logic                       control_spi_enable_o,
  output logic                       control_tx_fifo_reset_o,
  output logic                       control_rx_fifo_reset_o,
  output logic [SPI_RATIO_GRADE-1:0] spi_ratio_o,
  output logic                       tx_req_o,
  output logic [DATA_WIDTH-1:0]      tx_data_o,
  input  logic                       tx_ack_i,
  output logic                       rx_req_o,
  input  logic [DATA_WIDTH-1:0]      rx_data_i,
  input  logic                       rx_resp_i,
  output logic                       rx_ack_o,
  input  logic [REG_WIDTH-1:0]       status_i,
  input  logic [REG_WIDTH-1:0]       tx_occupancy_i,
  input  logic [REG_WIDTH-1:0]       rx_occupancy_i
);

  localparam logic [3:0] A_SRR   = 4'h0;
  localparam logic [3:0] A_CR    = 4'h1;
  localparam logic [3:0] A_DTR   = 4'h3;
  localparam logic [3:0] A_SR    = 4'h2;
  localparam logic [3:0] A_DRR   = 4'h4;
  localparam logic [3:0] A_SSR   = 4'h5;
  localparam logic [3:0] A_TXOCC = 4'h6;
  localparam logic [3:0] A_RXOCC = 4'h7;
  localparam logic [3:0] A_RATIO = 4'h8;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  localparam logic [REG_WIDTH-1:0] SRR_KEY = REG_WIDTH'(32'h0000_000A);

  typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_EXEC, R_RESP} r_state_t;

  w_state_t w_state_q, w_state_d;
  r_state_t r_state_q, r_state_d;

  logic aw_held_q, aw_held_d;
  logic w_held_q, w_held_d;
  logic aw_hs, w_hs, ar_hs, w_go;
  logic awready_q, wready_q, arready_q;
  logic [3:0] waddr_q, raddr_q;
  logic [REG_WIDTH-1:0] wdata_q, rdata_q, rd_val;
  logic [1:0] bresp_q, rresp_q;
  logic rd_ok;
  logic tx_req_q, rx_req_q;
  logic [DATA_WIDTH-1:0] tx_data_q;
  logic en_q, master_q, cpol_q, cpha_q, lsb_q, ssr_q;
  logic [SPI_RATIO_GRADE-1:0] ratio_q;
  logic soft_rst_q, txf_rst_q, rxf_rst_q;
  logic tx_full, rx_empty, w_dtr, r_drr;
  logic unused;

  assign unused = ^{s_axi_wstrb_i, s_axi_awaddr_i[1:0],
                    s_axi_araddr_i[1:0]};

  assign tx_full  = status_i[SR_TX_FULL_BIT];
  assign rx_empty = status_i[SR_RX_EMPTY_BIT];
  assign w_dtr    = (waddr_q == A_DTR);
  assign r_drr    = (raddr_q == A_DRR);

  assign aw_hs = s_axi_awvalid_i & awready_q;
  assign w_hs  = s_axi_wvalid_i & wready_q;
  assign ar_hs = s_axi_arvalid_i & arready_q;
  assign w_go  = (w_state_q == W_IDLE) &
                 (aw_held_q | aw_hs) & (w_held_q | w_hs);

  // write channel FSM
  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q | aw_hs;
    w_held_d  = w_held_q | w_hs;
    unique case (w_state_q)
      W_IDLE: begin
        if (w_go) begin
          w_state_d = W_EXEC;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
        end
      end
      W_EXEC: begin
        if (!w_dtr || (tx_req_q ? tx_ack_i : tx_full))
          w_state_d = W_RESP;
      end
      W_RESP: begin
        if (s_axi_bready_i) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awready_q <= (w_state_d == W_IDLE) & ~aw_held_d;
      wready_q  <= (w_state_d == W_IDLE) & ~w_held_d;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      waddr_q    <= '0;
      wdata_q    <= '0;
      bresp_q    <= OKAY;
      tx_req_q   <= 1'b0;
      tx_data_q  <= '0;
      en_q       <= 1'b0;
      master_q   <= 1'b0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      lsb_q      <= 1'b0;
      ssr_q      <= 1'b0;
      ratio_q    <= '0;
      soft_rst_q <= 1'b0;
      txf_rst_q  <= 1'b0;
      rxf_rst_q  <= 1'b0;
    end else begin
      soft_rst_q <= 1'b0;
      txf_rst_q  <= 1'b0;
      rxf_rst_q  <= 1'b0;
      if (aw_hs) waddr_q <= s_axi_awaddr_i[5:2];
      if (w_hs) wdata_q <= s_axi_wdata_i;
      if (w_state_q == W_EXEC) begin
        unique case (1'b1)
          w_dtr: begin
            if (!tx_req_q) begin
              if (tx_full) begin
                bresp_q <= SLVERR;
              end else begin
                tx_req_q  <= 1'b1;
                tx_data_q <= wdata_q[DATA_WIDTH-1:0];
              end
            end else if (tx_ack_i) begin
              tx_req_q <= 1'b0;
              bresp_q  <= OKAY;
            end
          end
          (waddr_q == A_SRR): begin
            bresp_q <= OKAY;
            if (wdata_q == SRR_KEY) begin
              soft_rst_q <= 1'b1;
              en_q       <= 1'b0;
              master_q   <= 1'b0;
              cpol_q     <= 1'b0;
              cpha_q     <= 1'b0;
              lsb_q      <= 1'b0;
              ssr_q      <= 1'b0;
              ratio_q    <= '0;
            end
          end
          (waddr_q == A_CR): begin
            bresp_q   <= OKAY;
            en_q      <= wdata_q[0];
            master_q  <= wdata_q[1];
            cpol_q    <= wdata_q[2];
            cpha_q    <= wdata_q[3];
            txf_rst_q <= wdata_q[4];
            rxf_rst_q <= wdata_q[5];
            lsb_q     <= wdata_q[6];
          end
          (waddr_q == A_SSR): begin
            bresp_q <= OKAY;
            ssr_q   <= wdata_q[0];
          end
          (waddr_q == A_RATIO): begin
            bresp_q <= OKAY;
            ratio_q <= wdata_q[SPI_RATIO_GRADE-1:0];
          end
          default: bresp_q <= SLVERR;
        endcase
      end
    end
  end

  // read value for non-FIFO offsets
  always_comb begin
    rd_val = '0;
    rd_ok  = 1'b1;
    unique case (1'b1)
      (raddr_q == A_CR):
        rd_val[6:0] = {lsb_q, 2'b00, cpha_q, cpol_q, master_q, en_q};
      (raddr_q == A_SR):    rd_val = status_i;
      (raddr_q == A_SSR):   rd_val[0] = ssr_q;
      (raddr_q == A_TXOCC): rd_val = tx_occupancy_i;
      (raddr_q == A_RXOCC): rd_val = rx_occupancy_i;
      (raddr_q == A_RATIO): rd_val[SPI_RATIO_GRADE-1:0] = ratio_q;
      default:              rd_ok = 1'b0;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (ar_hs) r_state_d = R_EXEC;
      end
      R_EXEC: begin
        if (!r_drr || (rx_req_q ? rx_resp_i : rx_empty))
          r_state_d = R_RESP;
      end
      R_RESP: begin
        if (s_axi_rready_i) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      raddr_q   <= '0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
      rx_req_q  <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= (r_state_d == R_IDLE);
      if (ar_hs) raddr_q <= s_axi_araddr_i[5:2];
      if (r_state_q == R_EXEC) begin
        if (r_drr) begin
          if (!rx_req_q) begin
            if (rx_empty) begin
              rdata_q <= '0;
              rresp_q <= SLVERR;
            end else begin
              rx_req_q <= 1'b1;
            end
          end else if (rx_resp_i) begin
            rx_req_q <= 1'b0;
            rdata_q  <= REG_WIDTH'(rx_data_i);
            rresp_q  <= OKAY;
          end
        end else begin
          rdata_q <= rd_val;
          rresp_q <= rd_ok ? OKAY : SLVERR;
        end
      end
    end
  end

  assign s_axi_awready_o = awready_q;
  assign s_axi_wready_o  = wready_q;
  assign s_axi_bvalid_o  = (w_state_q == W_RESP);
  assign s_axi_bresp_o   = bresp_q;
  assign s_axi_arready_o = arready_q;
  assign s_axi_rvalid_o  = (r_state_q == R_RESP);
  assign s_axi_rdata_o   = rdata_q;
  assign s_axi_rresp_o   = rresp_q;

  assign soft_rst_o              = soft_rst_q;
  assign slave_select_o          = ssr_q;
  assign control_lsb_o           = lsb_q;
  assign control_cpha_o          = cpha_q;
  assign control_cpol_o          = cpol_q;
  assign control_master_o        = master_q;
  assign control_spi_enable_o    = en_q;
  assign control_tx_fifo_reset_o = txf_rst_q;
  assign control_rx_fifo_reset_o = rxf_rst_q;
  assign spi_ratio_o             = ratio_q;

  assign tx_req_o  = tx_req_q;
  assign tx_data_o = tx_data_q;
  assign rx_req_o  = rx_req_q;
  assign rx_ack_o  = (r_state_q == R_EXEC) & rx_req_q & rx_resp_i;

endmodule

// File: tb/tb_axi_spi_regs.sv
// Directed self-checking bench for axi_spi_regs.
// Drives/samples on negedge; monitors count pulse and request cycles.
module tb_axi_spi_regs;

  localparam int AW = 6;
  localparam int RW = 32;
  localparam int DW = 8;
  localparam int RG = 2;

  logic          clk = 1'b0;
  logic          arst_n = 1'b0;
  logic [AW-1:0] awaddr = '0;
  logic          awvalid = 1'b0;
  logic          awready;
  logic [RW-1:0] wdata = '0;
  logic [3:0]    wstrb = 4'hF;
  logic          wvalid = 1'b0;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready = 1'b0;
  logic [AW-1:0] araddr = '0;
  logic          arvalid = 1'b0;
  logic          arready;
  logic [RW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready = 1'b0;
  logic          soft_rst, ss, lsb, cpha, cpol, master, en;
  logic          txf_rst, rxf_rst;
  logic [RG-1:0] ratio;
  logic          tx_req;
  logic [DW-1:0] tx_data;
  logic          tx_ack = 1'b0;
  logic          rx_req;
  logic [DW-1:0] rx_data = '0;
  logic          rx_resp = 1'b0;
  logic          rx_ack;
  logic [RW-1:0] status = '0;
  logic [RW-1:0] tx_occ = '0;
  logic [RW-1:0] rx_occ = '0;

  int n_assert = 0;
  int n_fail = 0;

  int txrst_cnt = 0, rxrst_cnt = 0, srst_cnt = 0;
  int txreq_cnt = 0, rxreq_cnt = 0, rxack_cnt = 0;
  int txdata_bad = 0, bhs_cnt = 0;
  logic [DW-1:0] exp_txdata = '0;

  always #5 clk = ~clk;

  axi_spi_regs #(
    .ADDR_WIDTH(AW), .REG_WIDTH(RW), .DATA_WIDTH(DW),
    .SPI_RATIO_GRADE(RG), .SR_RX_EMPTY_BIT(0), .SR_TX_FULL_BIT(3)
  ) dut (
    .clk_i(clk), .arst_n_i(arst_n),
    .s_axi_awaddr_i(awaddr), .s_axi_awvalid_i(awvalid),
    .s_axi_awready_o(awready),
    .s_axi_wdata_i(wdata), .s_axi_wstrb_i(wstrb),
    .s_axi_wvalid_i(wvalid), .s_axi_wready_o(wready),
    .s_axi_bresp_o(bresp), .s_axi_bvalid_o(bvalid),
    .s_axi_bready_i(bready),
    .s_axi_araddr_i(araddr), .s_axi_arvalid_i(arvalid),
    .s_axi_arready_o(arready),
    .s_axi_rdata_o(rdata), .s_axi_rresp_o(rresp),
    .s_axi_rvalid_o(rvalid), .s_axi_rready_i(rready),
    .soft_rst_o(soft_rst), .slave_select_o(ss),
    .control_lsb_o(lsb), .control_cpha_o(cpha),
    .control_cpol_o(cpol), .control_master_o(master),
    .control_spi_enable_o(en),
    .control_tx_fifo_reset_o(txf_rst),
    .control_rx_fifo_reset_o(rxf_rst),
    .spi_ratio_o(ratio),
    .tx_req_o(tx_req), .tx_data_o(tx_data), .tx_ack_i(tx_ack),
    .rx_req_o(rx_req), .rx_data_i(rx_data),
    .rx_resp_i(rx_resp), .rx_ack_o(rx_ack),
    .status_i(status), .tx_occupancy_i(tx_occ),
    .rx_occupancy_i(rx_occ)
  );

  always @(negedge clk) begin
    #1;
    if (txf_rst) txrst_cnt++;
    if (rxf_rst) rxrst_cnt++;
    if (soft_rst) srst_cnt++;
    if (tx_req) begin
      txreq_cnt++;
      if (tx_data !== exp_txdata) txdata_bad++;
    end
    if (rx_req) rxreq_cnt++;
    if (rx_ack) rxack_cnt++;
    if (bvalid && bready) bhs_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic do_write(input logic [AW-1:0] a,
                          input logic [RW-1:0] d,
                          output logic [1:0] resp);
    logic awf, wf;
    bit done;
    done = 0;
    resp = 2'bxx;
    @(negedge clk);
    awaddr = a; awvalid = 1'b1;
    wdata = d; wvalid = 1'b1;
    for (int t = 0; t < 40 && (awvalid || wvalid); t++) begin
      #1;
      awf = awvalid && awready;
      wf = wvalid && wready;
      @(negedge clk);
      if (awf) awvalid = 1'b0;
      if (wf) wvalid = 1'b0;
    end
    bready = 1'b1;
    for (int t = 0; t < 40 && !done; t++) begin
      #1;
      if (bvalid) begin
        resp = bresp;
        done = 1;
      end
      @(negedge clk);
    end
    bready = 1'b0;
    n_assert++;
    if (!done || awvalid || wvalid) begin
      n_fail++;
      $display("FAIL write_timeout addr=%h done=%0d required 1", a, done);
      awvalid = 1'b0;
      wvalid = 1'b0;
    end
  endtask

  task automatic do_read(input logic [AW-1:0] a,
                         output logic [RW-1:0] d,
                         output logic [1:0] resp);
    logic arf;
    bit done;
    done = 0;
    d = 'x;
    resp = 2'bxx;
    @(negedge clk);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    for (int t = 0; t < 40 && !done; t++) begin
      #1;
      arf = arvalid && arready;
      if (rvalid) begin
        d = rdata;
        resp = rresp;
        done = 1;
      end
      @(negedge clk);
      if (arf) arvalid = 1'b0;
    end
    rready = 1'b0;
    n_assert++;
    if (!done) begin
      n_fail++;
      $display("FAIL read_timeout addr=%h done=0 required 1", a);
      arvalid = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [RW-1:0] d;
    logic [1:0] r;
    repeat (2) @(negedge clk);
    #1;
    n_assert++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_handshake got=%b required 00000",
               {awready, wready, arready, bvalid, rvalid});
    end
    n_assert++;
    if ({soft_rst, ss, lsb, cpha, cpol, master, en, txf_rst,
         rxf_rst, ratio, tx_req, rx_req, rx_ack, bresp, rresp}
        !== 18'b0) begin
      n_fail++;
      $display("FAIL reset_outputs not all zero");
    end
    @(negedge clk);
    arst_n = 1'b1;
    repeat (2) @(negedge clk);
    do_read(6'h04, d, r);
    n_assert++;
    if ({d, r} !== {32'h0, 2'b00}) begin
      n_fail++;
      $display("FAIL reset_cr got=%h/%b required 0/00", d, r);
    end
    do_read(6'h14, d, r);
    n_assert++;
    if ({d, r} !== {32'h0, 2'b00}) begin
      n_fail++;
      $display("FAIL reset_ssr got=%h/%b required 0/00", d, r);
    end
    do_read(6'h20, d, r);
    n_assert++;
    if ({d, r} !== {32'h0, 2'b00}) begin
      n_fail++;
      $display("FAIL reset_ratio got=%h/%b required 0/00", d, r);
    end
  endtask

  task automatic test_cr_write();
    logic [RW-1:0] d;
    logic [1:0] r;
    int t0, r0;
    t0 = txrst_cnt;
    r0 = rxrst_cnt;
    do_write(6'h04, 32'h33, r);
    n_assert++;
    if (r !== 2'b00) begin
      n_fail++;
      $display("FAIL cr_bresp got=%b required 00", r);
    end
    n_assert++;
    if ({lsb, cpha, cpol, master, en} !== 5'b00011) begin
      n_fail++;
      $display("FAIL cr_levels got=%b required 00011",
               {lsb, cpha, cpol, master, en});
    end
    @(negedge clk);
    #2;
    n_assert++;
    if ((txrst_cnt - t0) != 1 || (rxrst_cnt - r0) != 1) begin
      n_fail++;
      $display("FAIL cr_fifo_rst_pulse got=%0d/%0d required 1/1",
               txrst_cnt - t0, rxrst_cnt - r0);
    end
    do_read(6'h04, d, r);
    n_assert++;
    if ({d, r} !== {32'h3, 2'b00}) begin
      n_fail++;
      $display("FAIL cr_readback got=%h/%b required 3/00", d, r);
    end
  endtask

  task automatic test_dtr();
    logic [1:0] r;
    int q0, b0;
    exp_txdata = 8'hA5;
    q0 = txreq_cnt;
    b0 = txdata_bad;
    fork
      do_write(6'h0C, 32'h1234_56A5, r);
      begin
        for (int t = 0; t < 40; t++) begin
          @(negedge clk);
          #1;
          if (tx_req) break;
        end
        repeat (3) @(negedge clk);
        tx_ack = 1'b1;
        @(negedge clk);
        tx_ack = 1'b0;
      end
    join
    n_assert++;
    if ((txreq_cnt - q0) != 4) begin
      n_fail++;
      $display("FAIL dtr_req_cycles got=%0d required 4", txreq_cnt - q0);
    end
    n_assert++;
    if ((txdata_bad - b0) != 0) begin
      n_fail++;
      $display("FAIL dtr_tx_data bad=%0d required 0", txdata_bad - b0);
    end
    n_assert++;
    if (r !== 2'b00 || tx_req !== 1'b0) begin
      n_fail++;
      $display("FAIL dtr_bresp got=%b req=%b required 00/0", r, tx_req);
    end
    status = 32'h8;
    q0 = txreq_cnt;
    do_write(6'h0C, 32'h77, r);
    n_assert++;
    if (r !== 2'b10 || (txreq_cnt - q0) != 0) begin
      n_fail++;
      $display("FAIL dtr_full got=%b reqs=%0d required 10/0",
               r, txreq_cnt - q0);
    end
    status = '0;
  endtask

  task automatic test_drr();
    logic [RW-1:0] d;
    logic [1:0] r;
    logic ack_seen;
    int q0, a0;
    ack_seen = 1'b0;
    rx_data = 8'h5C;
    q0 = rxreq_cnt;
    a0 = rxack_cnt;
    fork
      do_read(6'h10, d, r);
      begin
        for (int t = 0; t < 40; t++) begin
          @(negedge clk);
          #1;
          if (rx_req) break;
        end
        @(negedge clk);
        rx_resp = 1'b1;
        #1;
        ack_seen = rx_ack;
        @(negedge clk);
        rx_resp = 1'b0;
      end
    join
    n_assert++;
    if (ack_seen !== 1'b1 || (rxack_cnt - a0) != 1) begin
      n_fail++;
      $display("FAIL drr_ack got=%b/%0d required 1/1",
               ack_seen, rxack_cnt - a0);
    end
    n_assert++;
    if ((rxreq_cnt - q0) != 2) begin
      n_fail++;
      $display("FAIL drr_req_cycles got=%0d required 2", rxreq_cnt - q0);
    end
    n_assert++;
    if ({d, r} !== {32'h5C, 2'b00}) begin
      n_fail++;
      $display("FAIL drr_data got=%h/%b required 5c/00", d, r);
    end
    status = 32'h1;
    q0 = rxreq_cnt;
    do_read(6'h10, d, r);
    n_assert++;
    if ({d, r} !== {32'h0, 2'b10} || (rxreq_cnt - q0) != 0) begin
      n_fail++;
      $display("FAIL drr_empty got=%h/%b reqs=%0d required 0/10/0",
               d, r, rxreq_cnt - q0);
    end
    status = '0;
  endtask

  task automatic test_w_before_aw();
    logic wf, af;
    int b0, held;
    bit seen;
    b0 = bhs_cnt;
    held = 0;
    seen = 0;
    @(negedge clk);
    wdata = 32'h05; wvalid = 1'b1;
    #1;
    wf = wready;
    @(negedge clk);
    if (wf) wvalid = 1'b0;
    @(negedge clk);
    awaddr = 6'h04; awvalid = 1'b1;
    #1;
    af = awready;
    @(negedge clk);
    if (af) awvalid = 1'b0;
    n_assert++;
    if ({wf, af} !== 2'b11) begin
      n_fail++;
      $display("FAIL split_handshake got=%b required 11", {wf, af});
      wvalid = 1'b0;
      awvalid = 1'b0;
    end
    for (int t = 0; t < 20 && !seen; t++) begin
      #1;
      if (bvalid) seen = 1;
      else @(negedge clk);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      if (bvalid) held++;
    end
    n_assert++;
    if (!seen || held != 5) begin
      n_fail++;
      $display("FAIL bvalid_hold got=%0d required 5", held);
    end
    @(negedge clk);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    #2;
    n_assert++;
    if ((bhs_cnt - b0) != 1 || bvalid !== 1'b0 || bresp !== 2'b00) begin
      n_fail++;
      $display("FAIL split_complete got=%0d/%b/%b required 1/0/00",
               bhs_cnt - b0, bvalid, bresp);
    end
    n_assert++;
    if ({lsb, cpha, cpol, master, en} !== 5'b00101) begin
      n_fail++;
      $display("FAIL split_cr got=%b required 00101",
               {lsb, cpha, cpol, master, en});
    end
  endtask

  task automatic test_soft_reset();
    logic [RW-1:0] d;
    logic [1:0] r;
    int s0;
    do_write(6'h04, 32'h41, r);
    do_write(6'h20, 32'h3, r);
    n_assert++;
    if ({lsb, en, ratio} !== 4'b1111) begin
      n_fail++;
      $display("FAIL srr_setup got=%b required 1111", {lsb, en, ratio});
    end
    s0 = srst_cnt;
    do_write(6'h00, 32'h0A, r);
    @(negedge clk);
    #2;
    n_assert++;
    if (r !== 2'b00 || (srst_cnt - s0) != 1) begin
      n_fail++;
      $display("FAIL srr_pulse got=%b/%0d required 00/1", r, srst_cnt - s0);
    end
    do_read(6'h04, d, r);
    n_assert++;
    if ({d, r} !== {32'h0, 2'b00}) begin
      n_fail++;
      $display("FAIL srr_cr got=%h/%b required 0/00", d, r);
    end
    do_read(6'h20, d, r);
    n_assert++;
    if ({d, r} !== {32'h0, 2'b00} || {lsb, en, ratio} !== 4'b0) begin
      n_fail++;
      $display("FAIL srr_ratio got=%h/%b required 0/00", d, r);
    end
    s0 = srst_cnt;
    do_write(6'h00, 32'h05, r);
    @(negedge clk);
    #2;
    n_assert++;
    if (r !== 2'b00 || (srst_cnt - s0) != 0) begin
      n_fail++;
      $display("FAIL srr_bad_key got=%b/%0d required 00/0",
               r, srst_cnt - s0);
    end
  endtask

  task automatic test_map();
    logic [RW-1:0] d;
    logic [1:0] r;
    status = 32'hDEAD_0010;
    tx_occ = 32'd17;
    rx_occ = 32'd5;
    do_read(6'h08, d, r);
    n_assert++;
    if ({d, r} !== {32'hDEAD_0010, 2'b00}) begin
      n_fail++;
      $display("FAIL sr_read got=%h/%b required dead0010/00", d, r);
    end
    do_read(6'h1C, d, r);
    n_assert++;
    if ({d, r} !== {32'd5, 2'b00}) begin
      n_fail++;
      $display("FAIL rxocc_read got=%h/%b required 5/00", d, r);
    end
    do_read(6'h24, d, r);
    n_assert++;
    if ({d, r} !== {32'h0, 2'b10}) begin
      n_fail++;
      $display("FAIL unmapped_read got=%h/%b required 0/10", d, r);
    end
    do_read(6'h0C, d, r);
    n_assert++;
    if ({d, r} !== {32'h0, 2'b10}) begin
      n_fail++;
      $display("FAIL dtr_read got=%h/%b required 0/10", d, r);
    end
    do_write(6'h08, 32'hFFFF_FFFF, r);
    n_assert++;
    if (r !== 2'b10 || en !== 1'b0) begin
      n_fail++;
      $display("FAIL sr_write got=%b required 10", r);
    end
    do_write(6'h17, 32'hFFFF_FFFF, r);
    n_assert++;
    if (r !== 2'b00 || ss !== 1'b1) begin
      n_fail++;
      $display("FAIL ssr_write got=%b/%b required 00/1", r, ss);
    end
    do_read(6'h14, d, r);
    n_assert++;
    if ({d, r} !== {32'h1, 2'b00}) begin
      n_fail++;
      $display("FAIL ssr_read got=%h/%b required 1/00", d, r);
    end
    status = '0;
  endtask

  task automatic test_back_to_back();
    logic [RW-1:0] d;
    logic [1:0] rw, rr;
    fork
      do_write(6'h14, 32'h0, rw);
      do_read(6'h18, d, rr);
    join
    n_assert++;
    if (rw !== 2'b00 || ss !== 1'b0) begin
      n_fail++;
      $display("FAIL concurrent_write got=%b/%b required 00/0", rw, ss);
    end
    n_assert++;
    if ({d, rr} !== {32'd17, 2'b00}) begin
      n_fail++;
      $display("FAIL concurrent_read got=%h/%b required 11/00", d, rr);
    end
    do_write(6'h20, 32'h2, rw);
    do_read(6'h20, d, rr);
    n_assert++;
    if ({d, rr} !== {32'h2, 2'b00} || ratio !== 2'd2) begin
      n_fail++;
      $display("FAIL ratio_b2b got=%h/%b required 2/00", d, rr);
    end
  endtask

  initial begin
    test_reset();
    test_cr_write();
    test_dtr();
    test_drr();
    test_w_before_aw();
    test_soft_reset();
    test_map();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
